// File: rtl/cpu_test_harness_pkg.sv
// Shared definitions for the CPU test harness.
//   state_t      : harness FSM states
//   DEF_*        : parameter defaults used by the top and the halt detector
package cpu_test_harness_pkg;

  localparam int DEF_DATA_W        = 16;
  localparam int DEF_NUM_REGS      = 8;
  localparam int DEF_PC_W          = 16;
  localparam int DEF_RESET_CYCLES  = 5;
  localparam int DEF_STABLE_CYCLES = 4;
  localparam int DEF_MAX_CYCLES    = 1024;
  localparam int DEF_CNT_W         = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_HOLD_RST = 3'd1,
    ST_RUN      = 3'd2,
    ST_CHECK    = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

endpackage

// File: rtl/cpu_test_harness_halt.sv
// pc_halt_detect: declares a CPU halt when the program counter has matched
// its previous-cycle value on STABLE_CYCLES consecutive enabled cycles.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   clear      : restart detection (forgets the previous PC)
//   en         : sample pc_in this cycle (CPU running)
//   pc_in      : observed program counter
//   halted     : combinational, high on the cycle the halt condition is met
module pc_halt_detect
  import cpu_test_harness_pkg::*;
#(
  parameter int PC_W          = DEF_PC_W,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
)(
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            en,
  input  logic [PC_W-1:0] pc_in,
  output logic            halted
);

  localparam int SC_W = $clog2(STABLE_CYCLES + 1);

  logic [PC_W-1:0] prev_pc;
  logic            have_prev;
  logic [SC_W-1:0] stable_cnt;
  logic            same_pc;

  // Without a previous sample (first run cycle) nothing can count as stable.
  assign same_pc = have_prev && (pc_in == prev_pc);
  assign halted  = en && same_pc && (stable_cnt == SC_W'(STABLE_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      have_prev  <= 1'b0;
      stable_cnt <= '0;
    end else if (en) begin
      have_prev  <= 1'b1;
      stable_cnt <= same_pc ? stable_cnt + 1'b1 : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      prev_pc <= pc_in;
    end
  end

endmodule

// File: rtl/cpu_test_harness.sv
// cpu_test_harness: holds a CPU in reset, releases it, waits for the PC to
// settle (halt) or for a cycle budget to expire, then compares the CPU
// registers against loaded expected values, one register per cycle.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   start              : one-cycle pulse launching a run (IDLE/DONE only)
//   exp_we/addr/data   : load an expected register value (IDLE/DONE only)
//   pc_in, regs_flat   : observed CPU state; reg i at [i*DATA_W +: DATA_W]
//   cpu_reset          : CPU reset, low only while running
//   busy, done         : run in progress / run finished
//   pass, timeout      : run verdict, valid while done
//   fail_mask          : per-register mismatch flags
//   cycle_count        : run cycles elapsed, saturating
module cpu_test_harness
  import cpu_test_harness_pkg::*;
#(
  parameter int DATA_W        = DEF_DATA_W,
  parameter int NUM_REGS      = DEF_NUM_REGS,
  parameter int PC_W          = DEF_PC_W,
  parameter int RESET_CYCLES  = DEF_RESET_CYCLES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int MAX_CYCLES    = DEF_MAX_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
)(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         exp_we,
  input  logic [$clog2(NUM_REGS)-1:0]  exp_addr,
  input  logic [DATA_W-1:0]            exp_data,
  input  logic [PC_W-1:0]              pc_in,
  input  logic [NUM_REGS*DATA_W-1:0]   regs_flat,
  output logic                         cpu_reset,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic                         timeout,
  output logic [NUM_REGS-1:0]          fail_mask,
  output logic [CNT_W-1:0]             cycle_count
);

  localparam int AW   = $clog2(NUM_REGS);
  localparam int RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  localparam logic [AW-1:0]   CHK_LAST   = AW'(NUM_REGS - 1);
  localparam logic [RC_W-1:0] RST_LAST   = RC_W'(RESET_CYCLES - 1);
  localparam logic [AW:0]     NUM_REGS_V = (AW + 1)'(NUM_REGS);

  state_t              state;
  logic [RC_W-1:0]     rst_cnt;
  logic [AW-1:0]       chk_idx;
  logic [NUM_REGS-1:0] care;
  logic [DATA_W-1:0]   exp_mem [NUM_REGS];

  logic                cfg_ok;
  logic                start_ok;
  logic                addr_ok;
  logic                halted;
  logic                budget_hit;
  logic [DATA_W-1:0]   cur_reg;
  logic                mismatch;
  logic [NUM_REGS-1:0] mismatch_vec;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign cfg_ok    = (state == ST_IDLE) || (state == ST_DONE);
  assign start_ok  = start && cfg_ok;
  assign addr_ok   = ({1'b0, exp_addr} < NUM_REGS_V);

  assign cpu_reset = (state != ST_RUN);
  assign busy      = (state == ST_HOLD_RST) || (state == ST_RUN) || (state == ST_CHECK);
  assign done      = (state == ST_DONE);

  // This RUN cycle is the one that brings the count to MAX_CYCLES.
  assign budget_hit = 32'(cycle_count) >= 32'(MAX_CYCLES - 1);

  assign cur_reg  = regs_flat[chk_idx*DATA_W +: DATA_W];
  assign mismatch = care[chk_idx] && (cur_reg != exp_mem[chk_idx]);

  always_comb begin
    mismatch_vec          = '0;
    mismatch_vec[chk_idx] = mismatch;
  end

  pc_halt_detect #(
    .PC_W          (PC_W),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_halt (
    .clk    (clk),
    .reset  (reset),
    .clear  (start_ok),
    .en     (state == ST_RUN),
    .pc_in  (pc_in),
    .halted (halted)
  );

  always_ff @(posedge clk) begin
    if (!reset && cfg_ok && exp_we && addr_ok) begin
      exp_mem[exp_addr] <= exp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      rst_cnt     <= '0;
      chk_idx     <= '0;
      care        <= '0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
      fail_mask   <= '0;
      cycle_count <= '0;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state       <= ST_HOLD_RST;
            rst_cnt     <= '0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            fail_mask   <= '0;
            cycle_count <= '0;
          end
        end
        ST_HOLD_RST: begin
          if (rst_cnt == RST_LAST) begin
            state <= ST_RUN;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          cycle_count <= sat_inc(cycle_count);
          // A halt on the budget's last cycle still gets its registers checked.
          if (halted) begin
            state   <= ST_CHECK;
            chk_idx <= '0;
          end else if (budget_hit) begin
            state     <= ST_DONE;
            timeout   <= 1'b1;
            pass      <= 1'b0;
            fail_mask <= '0;
          end
        end
        ST_CHECK: begin
          if (mismatch) begin
            fail_mask[chk_idx] <= 1'b1;
          end
          if (chk_idx == CHK_LAST) begin
            state <= ST_DONE;
            // Fold in the compare made on this final cycle.
            pass  <= ((fail_mask | mismatch_vec) == '0) && !timeout;
          end else begin
            chk_idx <= chk_idx + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (cfg_ok && exp_we && addr_ok) begin
        care[exp_addr] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_test_harness.sv
// Testbench for cpu_test_harness: directed scenarios plus randomized runs,
// each checked against a behavioural model of the expected run outcome.
module tb_cpu_test_harness;

  localparam int DW = 16;
  localparam int NR = 8;
  localparam int PW = 16;
  localparam int RC = 5;
  localparam int SC = 4;
  localparam int MC = 64;
  localparam int CW = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              exp_we;
  logic [2:0]        exp_addr;
  logic [DW-1:0]     exp_data;
  logic [PW-1:0]     pc_in;
  logic [NR*DW-1:0]  regs_flat;
  logic              cpu_reset;
  logic              busy;
  logic              done;
  logic              pass;
  logic              timeout;
  logic [NR-1:0]     fail_mask;
  logic [CW-1:0]     cycle_count;

  int checks = 0;
  int errors = 0;

  // CPU stimulus and expectation model
  logic [PW-1:0] trace  [256];
  logic [DW-1:0] m_regs [NR];
  logic [DW-1:0] m_exp  [NR];
  bit            m_care [NR];

  always #5 clk = ~clk;

  cpu_test_harness #(
    .DATA_W        (DW),
    .NUM_REGS      (NR),
    .PC_W          (PW),
    .RESET_CYCLES  (RC),
    .STABLE_CYCLES (SC),
    .MAX_CYCLES    (MC),
    .CNT_W         (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .exp_we      (exp_we),
    .exp_addr    (exp_addr),
    .exp_data    (exp_data),
    .pc_in       (pc_in),
    .regs_flat   (regs_flat),
    .cpu_reset   (cpu_reset),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .timeout     (timeout),
    .fail_mask   (fail_mask),
    .cycle_count (cycle_count)
  );

  task automatic set_regs();
    for (int i = 0; i < NR; i++) regs_flat[i*DW +: DW] = m_regs[i];
  endtask

  task automatic write_exp(input int a, input logic [DW-1:0] d);
    exp_we   = 1'b1;
    exp_addr = 3'(a);
    exp_data = d;
    @(negedge clk);
    exp_we   = 1'b0;
    m_care[a] = 1'b1;
    m_exp[a]  = d;
  endtask

  task automatic trace_halt_at_16();
    for (int j = 0; j < 256; j++) trace[j] = (j < 8) ? PW'(2 * j) : 16'h0010;
  endtask

  task automatic trace_increment();
    for (int j = 0; j < 256; j++) trace[j] = PW'(j);
  endtask

  // One full run from start to DONE; inject=1 pulses start and exp_we mid-run.
  task automatic run_and_check(input string name, input bit inject);
    int hold, run, chk, stable, halt_at, exp_run, exp_chk;
    bit exp_to, exp_pass;
    logic [NR-1:0] exp_fm;
    logic [CW-1:0] exp_cc;

    halt_at = -1;
    stable  = 0;
    for (int j = 1; j < MC && halt_at < 0; j++) begin
      if (trace[j] == trace[j-1]) stable++;
      else stable = 0;
      if (stable == SC) halt_at = j;
    end
    exp_fm = '0;
    if (halt_at >= 0) begin
      exp_to  = 1'b0;
      exp_run = halt_at + 1;
      exp_chk = NR;
      for (int i = 0; i < NR; i++)
        if (m_care[i] && m_regs[i] != m_exp[i]) exp_fm[i] = 1'b1;
    end else begin
      exp_to  = 1'b1;
      exp_run = MC;
      exp_chk = 0;
    end
    exp_pass = (exp_fm == '0) && !exp_to;
    exp_cc   = CW'(exp_run);

    set_regs();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    checks++;
    if ({busy, done, pass, timeout, fail_mask, cycle_count} !== {1'b1, 1'b0, 1'b0, 1'b0, {NR{1'b0}}, {CW{1'b0}}}) begin
      errors++;
      $display("FAIL %s start_clear busy=%b done=%b pass=%b to=%b fm=%b cc=%0d want busy=1 rest 0",
               name, busy, done, pass, timeout, fail_mask, cycle_count);
    end

    hold = 0;
    while (busy && cpu_reset && hold < 100) begin
      hold++;
      @(negedge clk);
    end
    run = 0;
    while (busy && !cpu_reset && run < 200) begin
      pc_in  = trace[run];
      start  = inject && (run == 3);
      exp_we = inject && (run == 3);
      if (inject && run == 3) begin
        exp_addr = 3'd0;
        exp_data = ~m_regs[0];
      end
      run++;
      @(negedge clk);
    end
    start  = 1'b0;
    exp_we = 1'b0;
    chk = 0;
    while (busy && chk < 100) begin
      chk++;
      @(negedge clk);
    end

    checks++;
    if (hold !== RC) begin
      errors++;
      $display("FAIL %s hold_cycles got %0d want %0d", name, hold, RC);
    end
    checks++;
    if (run !== exp_run) begin
      errors++;
      $display("FAIL %s run_cycles got %0d want %0d", name, run, exp_run);
    end
    checks++;
    if (chk !== exp_chk) begin
      errors++;
      $display("FAIL %s check_cycles got %0d want %0d", name, chk, exp_chk);
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (done !== 1'b1 || cpu_reset !== 1'b1) begin
        errors++;
        $display("FAIL %s done[%0d] done=%b cpu_reset=%b want 1 1", name, k, done, cpu_reset);
      end
      checks++;
      if (pass !== exp_pass || timeout !== exp_to) begin
        errors++;
        $display("FAIL %s verdict[%0d] pass=%b timeout=%b want %b %b", name, k, pass, timeout, exp_pass, exp_to);
      end
      checks++;
      if (fail_mask !== exp_fm) begin
        errors++;
        $display("FAIL %s fail_mask[%0d] got %b want %b", name, k, fail_mask, exp_fm);
      end
      checks++;
      if (cycle_count !== exp_cc) begin
        errors++;
        $display("FAIL %s cycle_count[%0d] got %0d want %0d", name, k, cycle_count, exp_cc);
      end
      if (k == 0) repeat (3) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (cpu_reset !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl cpu_reset=%b busy=%b done=%b want 1 0 0", cpu_reset, busy, done);
    end
    checks++;
    if (pass !== 1'b0 || timeout !== 1'b0 || fail_mask !== '0 || cycle_count !== '0) begin
      errors++;
      $display("FAIL reset_out pass=%b to=%b fm=%b cc=%0d want all 0", pass, timeout, fail_mask, cycle_count);
    end
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || cpu_reset !== 1'b1) begin
      errors++;
      $display("FAIL reset_prio busy=%b cpu_reset=%b want 0 1", busy, cpu_reset);
    end
  endtask

  task automatic test_pass();
    write_exp(1, 16'd5);
    write_exp(2, 16'd7);
    for (int i = 0; i < NR; i++) m_regs[i] = DW'($urandom);
    m_regs[1] = 16'd5;
    m_regs[2] = 16'd7;
    trace_halt_at_16();
    run_and_check("pass", 1'b0);
  endtask

  task automatic test_mismatch();
    write_exp(3, 16'd9);
    m_regs[3] = 16'd8;
    trace_halt_at_16();
    run_and_check("mismatch", 1'b0);
  endtask

  task automatic test_back_to_back();
    m_regs[3] = 16'd9;
    trace_halt_at_16();
    run_and_check("rerun_inject", 1'b1);
  endtask

  task automatic test_timeout();
    trace_increment();
    run_and_check("timeout", 1'b0);
  endtask

  task automatic test_short_stall();
    logic [PW-1:0] pre [9];
    pre = '{16'd0, 16'd1, 16'd2, 16'd2, 16'd2, 16'd2, 16'd3, 16'd4, 16'd5};
    for (int j = 0; j < 256; j++) trace[j] = (j < 9) ? pre[j] : 16'd5;
    run_and_check("short_stall", 1'b0);
  endtask

  task automatic test_abort();
    int hold, run;
    write_exp(1, 16'd5);
    m_regs[1] = 16'd6;
    trace_increment();
    set_regs();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hold = 0;
    while (busy && cpu_reset && hold < 100) begin
      hold++;
      @(negedge clk);
    end
    run = 0;
    while (busy && !cpu_reset && run < 10) begin
      pc_in = trace[run];
      run++;
      @(negedge clk);
    end
    checks++;
    if (run !== 10 || cpu_reset !== 1'b0) begin
      errors++;
      $display("FAIL abort_reach run=%0d cpu_reset=%b want 10 0", run, cpu_reset);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < NR; i++) m_care[i] = 1'b0;
    checks++;
    if (cpu_reset !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || cycle_count !== '0) begin
      errors++;
      $display("FAIL abort_state cpu_reset=%b busy=%b done=%b cc=%0d want 1 0 0 0",
               cpu_reset, busy, done, cycle_count);
    end
    trace_halt_at_16();
    run_and_check("abort_rerun", 1'b0);
  endtask

  task automatic test_random();
    int nw, len, j;
    logic [PW-1:0] pcv;
    for (int n = 0; n < 20; n++) begin
      nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++) write_exp($urandom_range(0, NR - 1), DW'($urandom));
      for (int i = 0; i < NR; i++)
        m_regs[i] = (m_care[i] && $urandom_range(0, 1) == 1) ? m_exp[i] : DW'($urandom);
      pcv = PW'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        for (int k = 0; k < 256; k++) trace[k] = pcv + PW'(k);
      end else begin
        j = 0;
        while (j < 256) begin
          len = $urandom_range(1, 7);
          for (int k = 0; k < len && j < 256; k++) begin
            trace[j] = pcv;
            j++;
          end
          pcv = pcv + PW'($urandom_range(1, 4));
        end
      end
      run_and_check("random", 1'b0);
    end
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    exp_we    = 1'b0;
    exp_addr  = '0;
    exp_data  = '0;
    pc_in     = '0;
    regs_flat = '0;
    for (int i = 0; i < NR; i++) begin
      m_regs[i] = '0;
      m_exp[i]  = '0;
      m_care[i] = 1'b0;
    end
    @(negedge clk);
    test_reset();
    test_pass();
    test_mismatch();
    test_back_to_back();
    test_timeout();
    test_short_stall();
    test_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cpu_test_harness.md
CPU_TEST_HARNESS -- requirements
Module: cpu_test_harness

Interface
REQ-001 SHALL have parameter DATA_W, default 16, width of one CPU register.
REQ-002 SHALL have parameter NUM_REGS, default 8, number of observed CPU registers; range 2..32.
REQ-003 SHALL have parameter PC_W, default 16, width of the observed program counter.
REQ-004 SHALL have parameter RESET_CYCLES, default 5, number of cycles cpu_reset is held after start.
REQ-005 SHALL have parameter STABLE_CYCLES, default 4, number of consecutive unchanged-PC cycles that count as a halt.
REQ-006 SHALL have parameter MAX_CYCLES, default 1024, run-cycle budget before timeout.
REQ-007 SHALL have parameter CNT_W, default 16, width of cycle_count.
REQ-008 Ports SHALL be exactly:
 clk  in  1  single clock; all state updates on its rising edge
 reset  in  1  synchronous, active-high
 start  in  1  one-cycle pulse that launches a test run
 exp_we  in  1  expected-value write strobe
 exp_addr  in  $clog2(NUM_REGS)  register index for exp_data
 exp_data  in  DATA_W  expected final register value
 pc_in  in  PC_W  CPU program counter
 regs_flat  in  NUM_REGS*DATA_W  CPU registers; reg i occupies bits [i*DATA_W +: DATA_W]
 cpu_reset  out  1  drives CPU reset
 busy  out  1  high from start acceptance until done
 done  out  1  held high while in DONE
 pass  out  1  valid while done
 timeout  out  1  run ended on cycle budget
 fail_mask  out  NUM_REGS  bit i set means register i mismatched
 cycle_count  out  CNT_W  run cycles elapsed, saturating

Function
REQ-009 FSM states SHALL be IDLE, HOLD_RST, RUN, CHECK, DONE.
REQ-010 In IDLE and DONE, exp_we SHALL write exp_data into exp[exp_addr] and set care[exp_addr]; exp_we in any other state SHALL be ignored.
REQ-011 start in IDLE or DONE SHALL move to HOLD_RST and clear fail_mask, timeout, pass, done, cycle_count, and the stability counter; start in any other state SHALL be ignored.
REQ-012 HOLD_RST SHALL assert cpu_reset for exactly RESET_CYCLES cycles, then enter RUN with cpu_reset low.
REQ-013 cpu_reset SHALL be high in IDLE, HOLD_RST, CHECK and DONE, and low only in RUN.
REQ-014 In RUN, cycle_count SHALL increment by 1 per cycle and saturate at 2**CNT_W-1.
REQ-015 In RUN, a halt SHALL be declared when pc_in equals its previous-cycle value on STABLE_CYCLES consecutive cycles; any change SHALL reset the stability count to 0; the first RUN cycle SHALL never count as stable.
REQ-016 On halt, the FSM SHALL enter CHECK on the next cycle.
REQ-017 If cycle_count reaches MAX_CYCLES without a halt, the FSM SHALL enter DONE with timeout=1, pass=0, fail_mask=0, and SHALL skip CHECK; if halt and budget occur on the same cycle, halt SHALL win.
REQ-018 CHECK SHALL examine one register per cycle, index 0..NUM_REGS-1, taking exactly NUM_REGS cycles, and SHALL set fail_mask[i] when care[i]=1 and reg i != exp[i]; registers with care[i]=0 SHALL never fail.
REQ-019 After the last index the FSM SHALL enter DONE with pass = (fail_mask==0) & ~timeout, with the final compare included.
REQ-020 Outputs pass, timeout, fail_mask and cycle_count SHALL hold stable in DONE until the next start or reset.
REQ-021 busy SHALL be high in HOLD_RST, RUN and CHECK.

Reset
REQ-022 reset SHALL take priority over every other input and force: state=IDLE, cpu_reset=1, busy=0, done=0, pass=0, timeout=0, fail_mask=0, cycle_count=0, all care bits=0.
REQ-023 exp contents need not be cleared by reset; care bits alone gate comparison.
REQ-024 reset asserted mid-RUN or mid-CHECK SHALL abort the run with no done pulse.

Structure
REQ-025 A shared package SHALL hold the FSM state enum and the parameter defaults.
REQ-026 Halt detection (the previous-PC register and stability counter) SHALL be a sub-module, pc_halt_detect, with ports clk, reset, clear, en, pc_in and halted.

Verification
REQ-027 Case 1, pass: expect r1=5, r2=7; CPU model halts at PC=0x0010 with r1=5, r2=7 -> done=1, pass=1, fail_mask=0.
REQ-028 Case 2, mismatch: expect r3=9; r3 ends at 8 -> pass=0, fail_mask=8'b0000_1000.
REQ-029 Case 3, timeout: PC increments forever with MAX_CYCLES=64 -> done after 64 RUN cycles, timeout=1, pass=0, fail_mask=0.
REQ-030 Case 4, reset timing: after start, cpu_reset is high for exactly 5 cycles, then low; the PC repeating only 3 cycles, then changing, does not trigger CHECK.
REQ-031 Case 5, abort: reset at RUN cycle 10 -> next cycle state=IDLE, cpu_reset=1, care bits cleared; a new run with no expects gives pass=1.
REQ-032 Case 6, rerun from DONE: start in DONE clears fail_mask and cycle_count; start and exp_we asserted during RUN are ignored.
